// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Sequences a WIDTH-bit shift register for a full-duplex serial transfer.
//   A start request in IDLE loads data_in, then the word is shifted out
//   MSB-first on ser_out while ser_in is captured into the vacated LSB, one
//   bit every DIV clocks. After WIDTH shifts the received word appears on
//   data_out and done pulses for one cycle.
//
// Parameters
//   WIDTH : bits per transfer (2..32)
//   DIV   : clock cycles per shift (1..256, 1 = shift every cycle)
//
// Ports
//   clock    : rising-edge system clock
//   reset    : asynchronous, active-high; aborts any transfer, returns to IDLE
//   start    : transfer request, honoured only in IDLE
//   data_in  : parallel word to transmit, captured when LOAD exits
//   ser_in   : serial receive bit, captured on each shift edge
//   ser_out  : serial transmit bit (MSB of shift register while shifting)
//   shift_en : high in the cycle that ends in a shift edge
//   busy     : high in LOAD, SHIFT and DONE
//   done     : one-cycle completion pulse
//   data_out : last completed received word
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    // A 1-bit divider counter is kept even for DIV=1; it simply stays at 0.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  shreg_reg;
    logic [WIDTH-1:0]  data_out_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;

    logic              shift_tick;
    logic              last_shift;
    logic [WIDTH-1:0]  shifted;

    // Shift timing is decoded purely from registered state so shift_en and
    // ser_out are glitch-free for the whole cycle preceding the shift edge.
    assign shift_tick = (state_reg == SHIFT) && (div_cnt_reg == DIV_LAST);
    assign last_shift = shift_tick && (bit_cnt_reg == BIT_LAST);
    assign shifted    = {shreg_reg[WIDTH-2:0], ser_in};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start outside IDLE is dropped, never queued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
        shift_en = shift_tick;
        ser_out  = (state_reg == SHIFT) ? shreg_reg[WIDTH-1] : 1'b0;
    end

    // Shift datapath and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_reg    <= '0;
            data_out_reg <= '0;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    shreg_reg   <= data_in;
                    div_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                end
                SHIFT: begin
                    div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
                    if (shift_tick) begin
                        shreg_reg   <= shifted;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    // The final received bit goes straight into data_out on
                    // the same edge it is sampled.
                    if (last_shift) begin
                        data_out_reg <= shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out = data_out_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Two instances: dut_a (WIDTH=4, DIV=1) with selectable loopback or driven
//   ser_in, and dut_b (WIDTH=4, DIV=3) in loopback. Stimulus pushes the
//   expected outcome of each transfer into a per-instance queue; a monitor
//   process samples outputs on the falling edge and checks each completed
//   transfer (data_out, transmitted bit stream, shift count/timing, busy
//   length, done spacing) when done is presented.
module tb_shift_sequencer;

    typedef struct {
        logic [3:0] data;
        logic [3:0] ser;
        int         busy;
        int         gap;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;

    logic       a_start, a_ser_in, a_ser_out, a_shift_en, a_busy, a_done;
    logic [3:0] a_data_in, a_data_out;
    logic       a_loop, a_ser_drv;

    logic       b_start, b_ser_in, b_ser_out, b_shift_en, b_busy, b_done;
    logic [3:0] b_data_in, b_data_out;

    exp_t a_q[$];
    exp_t b_q[$];

    int   n_checks = 0;
    int   n_fails  = 0;
    int   tmo      = 0;
    int   cyc      = 0;
    bit   end_req  = 1'b0;
    bit   end_done = 1'b0;

    int         a_bcnt, a_scnt, a_last_done;
    int         b_bcnt, b_scnt;
    logic [3:0] a_ser, b_ser;

    always #5 clock = ~clock;

    assign a_ser_in = a_loop ? a_ser_out : a_ser_drv;
    assign b_ser_in = b_ser_out;

    shift_sequencer #(.WIDTH(4), .DIV(1)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .start    (a_start),
        .data_in  (a_data_in),
        .ser_in   (a_ser_in),
        .ser_out  (a_ser_out),
        .shift_en (a_shift_en),
        .busy     (a_busy),
        .done     (a_done),
        .data_out (a_data_out)
    );

    shift_sequencer #(.WIDTH(4), .DIV(3)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .start    (b_start),
        .data_in  (b_data_in),
        .ser_in   (b_ser_in),
        .ser_out  (b_ser_out),
        .shift_en (b_shift_en),
        .busy     (b_busy),
        .done     (b_done),
        .data_out (b_data_out)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        if (a_busy) a_bcnt++;
        if (!a_busy)
            chk("a_idle_outputs", 32'({a_done, a_shift_en, a_ser_out}), 32'd0);
        if (a_shift_en) begin
            a_ser = {a_ser[2:0], a_ser_out};
            a_scnt++;
            chk("a_shift_timing", 32'(a_bcnt), 32'(1 + 1 * a_scnt));
        end
        if (a_done) begin
            chk("a_done_outputs", 32'({a_shift_en, a_ser_out, a_busy}), 32'd1);
            if (a_q.size() == 0) begin
                chk("a_unexpected_done", 32'(a_q.size()), 32'd1);
            end else begin
                e = a_q.pop_front();
                chk("a_data_out", 32'(a_data_out), 32'(e.data));
                chk("a_ser_stream", 32'(a_ser), 32'(e.ser));
                chk("a_shift_count", 32'(a_scnt), 32'd4);
                chk("a_busy_cycles", 32'(a_bcnt), 32'(e.busy));
                if (e.gap != 0)
                    chk("a_done_spacing", 32'(cyc - a_last_done), 32'(e.gap));
            end
            $display("dut_a transfer done: data_out=%b ser=%b shifts=%0d busy=%0d", a_data_out, a_ser, a_scnt, a_bcnt);
            a_last_done = cyc;
            a_bcnt = 0;
            a_scnt = 0;
            a_ser  = '0;
        end
    endtask

    task automatic mon_b();
        exp_t e;
        if (b_busy) b_bcnt++;
        if (!b_busy)
            chk("b_idle_outputs", 32'({b_done, b_shift_en, b_ser_out}), 32'd0);
        if (b_shift_en) begin
            b_ser = {b_ser[2:0], b_ser_out};
            b_scnt++;
            chk("b_shift_timing", 32'(b_bcnt), 32'(1 + 3 * b_scnt));
        end
        if (b_done) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_done", 32'(b_q.size()), 32'd1);
            end else begin
                e = b_q.pop_front();
                chk("b_data_out", 32'(b_data_out), 32'(e.data));
                chk("b_ser_stream", 32'(b_ser), 32'(e.ser));
                chk("b_shift_count", 32'(b_scnt), 32'd4);
                chk("b_busy_cycles", 32'(b_bcnt), 32'(e.busy));
            end
            $display("dut_b transfer done: data_out=%b ser=%b shifts=%0d busy=%0d", b_data_out, b_ser, b_scnt, b_bcnt);
            b_bcnt = 0;
            b_scnt = 0;
            b_ser  = '0;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        a_bcnt = 0; a_scnt = 0; a_ser = '0; a_last_done = 0;
        b_bcnt = 0; b_scnt = 0; b_ser = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                chk("a_reset_outputs", 32'({a_busy, a_done, a_shift_en, a_ser_out, a_data_out}), 32'd0);
                chk("b_reset_outputs", 32'({b_busy, b_done, b_shift_en, b_ser_out, b_data_out}), 32'd0);
                a_bcnt = 0; a_scnt = 0; a_ser = '0;
                b_bcnt = 0; b_scnt = 0; b_ser = '0;
            end else begin
                mon_a();
                mon_b();
            end
            if (end_req && !end_done) begin
                chk("a_pending_transfers", 32'(a_q.size()), 32'd0);
                chk("b_pending_transfers", 32'(b_q.size()), 32'd0);
                chk("wait_timeouts", 32'(tmo), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((a_busy || b_busy) && n < 200);
        if (n >= 200) tmo++;
    endtask

    // Stimulus
    initial begin
        int         n;
        int         k;
        int         nd;
        logic [3:0] pat;

        reset = 1'b1;
        a_start = 1'b0; a_data_in = '0; a_loop = 1'b1; a_ser_drv = 1'b0;
        b_start = 1'b0; b_data_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Loopback 1011, DIV=1
        a_q.push_back('{4'b1011, 4'b1011, 6, 0});
        a_data_in = 4'b1011;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_idle();
        tick();

        // Receive 0,1,1,0 while transmitting zeros
        a_loop = 1'b0;
        a_data_in = 4'b0000;
        pat = 4'b0110;
        a_q.push_back('{4'b0110, 4'b0000, 6, 0});
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        k = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (a_shift_en && k < 4) begin
                a_ser_drv = pat[3-k];
                k++;
            end
        end while (a_busy && n < 50);
        if (n >= 50) tmo++;
        a_loop = 1'b1;
        tick();

        // DIV=3 loopback 1100
        b_q.push_back('{4'b1100, 4'b1100, 14, 0});
        b_data_in = 4'b1100;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_idle();
        tick();

        // start during SHIFT and during DONE is ignored
        a_data_in = 4'b1110;
        a_q.push_back('{4'b1110, 4'b1110, 6, 0});
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin
            tick();
            n++;
        end
        if (!a_done) tmo++;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (10) tick();

        // Reset after two shifts aborts the transfer, no done
        a_data_in = 4'b1010;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        a_q.push_back('{4'b0101, 4'b0101, 6, 0});
        a_data_in = 4'b0101;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_idle();
        tick();

        // start held high: back-to-back 1001 then 0110, dones 7 cycles apart
        a_q.push_back('{4'b1001, 4'b1001, 6, 0});
        a_q.push_back('{4'b0110, 4'b0110, 6, 7});
        a_data_in = 4'b1001;
        a_start = 1'b1;
        tick();
        tick();
        a_data_in = 4'b0110;
        nd = 0;
        n = 0;
        while (nd < 2 && n < 100) begin
            tick();
            n++;
            if (a_done) nd++;
        end
        if (nd < 2) tmo++;
        a_start = 1'b0;
        wait_idle();
        repeat (5) tick();

        end_req = 1'b1;
        n = 0;
        while (!end_done && n < 10) begin
            tick();
            n++;
        end
        if (!end_done) begin
            $display("FAIL monitor_end: final checks not reached");
            $fatal(1, "monitor stalled");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
